// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master serial bus arbiter with address snoop, timeout and optional ARB_ROUND_ROBIN_EN
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SEL_BITS       = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m1_req,
    input  logic                       m2_req,
    input  logic                       m1_release,
    input  logic                       m2_release,
    input  logic                       addr_valid,
    input  logic                       rx_address,
    output logic                       m1_grant,
    output logic                       m2_grant,
    output logic [(1<<SEL_BITS)-1:0]   slave_sel,
    output logic                       bus_busy,
    output logic                       timeout
);

    localparam int NSEL = 1 << SEL_BITS;
    localparam int BW   = (SEL_BITS > 1) ? $clog2(SEL_BITS) : 1;
    localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SEL_BITS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, XFER} state_t;

    state_t              state, state_nx;
    logic                owner;          // 0 = master 1, 1 = master 2
    logic [7:0]          cyc_cnt;
    logic [BW-1:0]       bit_cnt;
    logic [SEL_BITS-1:0] id_reg, id_full;
    logic [NSEL-1:0]     sel_reg, sel_dec;
    logic                timeout_q;
    logic                own_req, own_rel, term_rel, term_to, last_bit, pick_m2;
`ifdef ARB_ROUND_ROBIN_EN
    logic                last_owner;
`endif

    always_comb begin
        own_req  = owner ? m2_req : m1_req;
        own_rel  = owner ? m2_release : m1_release;
        term_rel = own_rel | ~own_req;
        term_to  = (cyc_cnt == TO_LAST);
        last_bit = addr_valid && (bit_cnt == BIT_LAST);
`ifdef ARB_ROUND_ROBIN_EN
        pick_m2  = m2_req && (!m1_req || !last_owner);
`else
        pick_m2  = m2_req && !m1_req;
`endif
    end

    // ID including the bit being shifted this cycle, so slave_sel lands on the last-bit edge
    always_comb begin
        id_full          = id_reg;
        id_full[bit_cnt] = rx_address;
        sel_dec          = '0;
        sel_dec[id_full] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (m1_req || m2_req) state_nx = ADDR;
            ADDR: begin
                if (term_rel || term_to) state_nx = IDLE;
                else if (last_bit)       state_nx = XFER;
            end
            XFER: if (term_rel || term_to) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= 1'b0;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            id_reg     <= '0;
            sel_reg    <= '0;
            timeout_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= 1'b1;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (m1_req || m2_req) begin
                        owner   <= pick_m2;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        id_reg  <= '0;
                    end
                end
                ADDR, XFER: begin
                    if (cyc_cnt != 8'hFF) cyc_cnt <= cyc_cnt + 8'd1;
                    if (term_rel || term_to) begin
                        sel_reg    <= '0;
                        timeout_q  <= ~term_rel;
`ifdef ARB_ROUND_ROBIN_EN
                        last_owner <= owner;
`endif
                    end else if (state == ADDR && addr_valid) begin
                        id_reg[bit_cnt] <= rx_address;
                        bit_cnt         <= bit_cnt + BW'(1);
                        if (last_bit) sel_reg <= sel_dec;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_busy  = (state != IDLE);
        m1_grant  = bus_busy && !owner;
        m2_grant  = bus_busy && owner;
        slave_sel = sel_reg;
        timeout   = timeout_q;
    end

endmodule
